// File: rtl/mpu341_pkg.sv
// Shared MPU341 data-memory definitions: RAM geometry and the host/CU
// arbiter state encoding.
package mpu341_pkg;

  localparam int MPU341_DM_ADDR_W = 4;
  localparam int MPU341_DM_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dm_arb_state_t;

  // Add one to an 8-bit statistic, sticking at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc8 = 8'hFF;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/dm_wait_timer.sv
// Saturating host wait counter. Cleared while no host request is waiting,
// advanced on every waiting cycle the host is not granted. The counter port
// only exists when DM_ARB_STATS_EN is defined (it feeds the wait statistics).
module dm_wait_timer #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
`ifdef DM_ARB_STATS_EN
  output logic [CNT_W-1:0] count,
`endif
  output logic             expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] cnt;

  assign expire = (cnt == LAST);
`ifdef DM_ARB_STATS_EN
  assign count = cnt;
`endif

  // Wait counter: clear has priority, then count up to LAST and hold there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt <= {CNT_W{1'b0}};
    end else if (en && !expire) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/dm_access_arbiter.sv
// Data-memory access arbiter for MPU341. Shares the 16x4 RAM (clocked on
// ~clk) between the CU, which has priority, and a host/debug port that takes
// any idle CU cycle. If the host has waited MAX_WAIT-1 cycles, the next busy
// CU cycle is stolen: mpu_stall holds the CU and the CU write is suppressed.
// Optional statistics ports are enabled with DM_ARB_STATS_EN.
module dm_access_arbiter
  import mpu341_pkg::*;
#(
  parameter int ADDR_W   = MPU341_DM_ADDR_W,
  parameter int DATA_W   = MPU341_DM_DATA_W,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mpu_access,
  input  logic              mpu_wren,
  input  logic [ADDR_W-1:0] mpu_addr,
  input  logic [DATA_W-1:0] mpu_wdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mpu_stall,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              host_grant
`ifdef DM_ARB_STATS_EN
  ,
  output logic [7:0]        steal_count,
  output logic [7:0]        host_wait_max
`endif
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  dm_arb_state_t state;
  logic          expire;
  logic          steal;
  logic          grant;
  logic          waiting;
  logic          timer_clr;
  logic          timer_en;
`ifdef DM_ARB_STATS_EN
  logic [CNT_W-1:0] wait_cnt;
`endif

  // Grant/steal decision for a host request that is still held in WAIT.
  always_comb begin
    waiting = 1'b0;
    steal   = 1'b0;
    grant   = 1'b0;
    if ((state == WAIT) && host_req) begin
      waiting = 1'b1;
      steal   = expire && mpu_access;
      grant   = !mpu_access || (expire && mpu_access);
    end else begin
      waiting = 1'b0;
      steal   = 1'b0;
      grant   = 1'b0;
    end
  end

  assign timer_clr  = (state != WAIT);
  assign timer_en   = waiting && !grant;
  assign mpu_stall  = steal;
  assign host_grant = grant;

  dm_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (timer_clr),
    .en     (timer_en),
`ifdef DM_ARB_STATS_EN
    .count  (wait_cnt),
`endif
    .expire (expire)
  );

  // RAM port mux: host owns the port only on its granted cycle, so a stolen
  // cycle never carries the CU write.
  always_comb begin
    ram_addr  = mpu_addr;
    ram_wdata = mpu_wdata;
    ram_wren  = mpu_wren;
    if (grant) begin
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
      ram_wren  = host_we;
    end else begin
      ram_addr  = mpu_addr;
      ram_wdata = mpu_wdata;
      ram_wren  = mpu_wren;
    end
  end

  // Request FSM with registered ack and read-data capture (RAM q is valid
  // by the posedge that ends the granted cycle).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      host_ack   <= 1'b0;
      host_rdata <= {DATA_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          host_ack <= 1'b0;
          if (host_req) begin
            state <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (!host_req) begin
            state    <= IDLE;
            host_ack <= 1'b0;
          end else if (grant) begin
            state    <= ACK;
            host_ack <= 1'b1;
            if (!host_we) begin
              host_rdata <= ram_q;
            end else begin
              host_rdata <= host_rdata;
            end
          end else begin
            state    <= WAIT;
            host_ack <= 1'b0;
          end
        end
        ACK: begin
          state    <= IDLE;
          host_ack <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          host_ack <= 1'b0;
        end
      endcase
    end
  end

`ifdef DM_ARB_STATS_EN
  // Statistics: saturating steal count and the longest wait seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      steal_count   <= 8'h00;
      host_wait_max <= 8'h00;
    end else begin
      if (steal) begin
        steal_count <= sat_inc8(steal_count);
      end else begin
        steal_count <= steal_count;
      end
      if ((state == WAIT) && (8'(wait_cnt) > host_wait_max)) begin
        host_wait_max <= 8'(wait_cnt);
      end else begin
        host_wait_max <= host_wait_max;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Self-checking bench for dm_access_arbiter. Stimulus pushes the expected
// grant/ack/steal timing and data into queues; a monitor compares them
// against whatever the DUT presents. Define DM_ARB_STATS_EN to also cover
// the statistics ports.
module tb_dm_access_arbiter;

  localparam int AW = 4;
  localparam int DW = 4;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mpu_access = 1'b0, mpu_wren = 1'b0;
  logic [AW-1:0] mpu_addr = '0, host_addr = '0, ram_addr;
  logic [DW-1:0] mpu_wdata = '0, host_wdata = '0, ram_wdata, host_rdata;
  logic [DW-1:0] ram_q = '0;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic          host_ack, mpu_stall, ram_wren, host_grant;
`ifdef DM_ARB_STATS_EN
  logic [7:0]    steal_count, host_wait_max;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [DW-1:0] ram     [0:15];
  logic [DW-1:0] ref_mem [0:15];

  typedef struct {
    int            grant_cyc;
    int            ack_cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   stall_q[$];

  dm_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk        (clk),
    .reset      (reset),
    .mpu_access (mpu_access),
    .mpu_wren   (mpu_wren),
    .mpu_addr   (mpu_addr),
    .mpu_wdata  (mpu_wdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .mpu_stall  (mpu_stall),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q),
    .host_grant (host_grant)
`ifdef DM_ARB_STATS_EN
    ,
    .steal_count   (steal_count),
    .host_wait_max (host_wait_max)
`endif
  );

  always #5 clk = ~clk;

  // Cycle counter: cycle n starts at the n-th posedge.
  always @(posedge clk) cyc <= cyc + 1;

  // Data-memory RAM model, clocked on ~clk.
  always @(negedge clk) begin
    if (ram_wren) ram[ram_addr] <= ram_wdata;
    ram_q <= ram[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: compare every grant, stall and ack with the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (reset) begin
      if (host_grant) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 32'(host_grant), 32'd0);
        end else begin
          e = exp_q[0];
          chk("grant_cycle", 32'(cyc), 32'(e.grant_cyc));
          chk("grant_addr", 32'(ram_addr), 32'(e.addr));
          chk("grant_wren", 32'(ram_wren), 32'(e.we));
          if (e.we) chk("grant_wdata", 32'(ram_wdata), 32'(e.data));
        end
      end
      if (mpu_stall) begin
        if (stall_q.size() == 0) chk("unexpected_stall", 32'(mpu_stall), 32'd0);
        else chk("stall_cycle", 32'(cyc), 32'(stall_q.pop_front()));
      end
      if (host_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'(host_ack), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
          if (!e.we) chk("read_data", 32'(host_rdata), 32'(e.data));
        end
      end
    end
  end

  // One host access. busy[t] is the CU activity in cycle issue+t; the model
  // expects the grant on the first idle cycle, or a steal at offset MW.
  task automatic do_req(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [MW:1] busy,
                        input bit hold, input bit cu_wr_steal,
                        input logic [AW-1:0] cu_addr);
    exp_t e;
    int   k;
    int   issue;
    bit   done;
    @(posedge clk); #1;
    issue      = cyc;
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = addr;
    host_wdata = wdata;
    mpu_access = 1'($urandom_range(0, 1));
    mpu_wren   = 1'b0;
    mpu_addr   = AW'($urandom);
    k = MW;
    for (int j = MW; j >= 1; j--) if (!busy[j]) k = j;
    e.grant_cyc = issue + k;
    e.ack_cyc   = issue + k + 1;
    e.we        = we;
    e.addr      = addr;
    e.data      = we ? wdata : ref_mem[addr];
    if (we) ref_mem[addr] = wdata;
    if (&busy) stall_q.push_back(issue + MW);
    exp_q.push_back(e);
    done = 1'b0;
    for (int t = 1; t <= 4 * MW + 8 && !done; t++) begin
      @(posedge clk); #1;
      if (host_ack) begin
        done       = 1'b1;
        mpu_access = 1'b0;
        mpu_wren   = 1'b0;
        if (!hold) host_req = 1'b0;
      end else begin
        mpu_access = (t <= MW) ? busy[t] : 1'($urandom_range(0, 1));
        mpu_wren   = 1'b0;
        mpu_addr   = AW'($urandom);
        mpu_wdata  = DW'($urandom);
        if (cu_wr_steal && t == MW) begin
          mpu_access = 1'b1;
          mpu_wren   = 1'b1;
          mpu_addr   = cu_addr;
          mpu_wdata  = ~ref_mem[cu_addr];
        end
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack expected ack by cycle %0d", e.ack_cyc);
      host_req = 1'b0;
      exp_q.delete();
      stall_q.delete();
    end
  endtask

  // Host idle cycles; the CU optionally writes (such writes always commit).
  task automatic idle(input int n, input bit cu_wr);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      host_req   = 1'b0;
      a          = AW'($urandom);
      d          = DW'($urandom);
      mpu_access = 1'($urandom_range(0, 1));
      mpu_wren   = cu_wr && mpu_access;
      mpu_addr   = a;
      mpu_wdata  = d;
      if (mpu_wren) ref_mem[a] = d;
    end
    @(posedge clk); #1;
    mpu_access = 1'b0;
    mpu_wren   = 1'b0;
  endtask

  initial begin
    logic [MW:1]   busy;
    logic [DW-1:0] d;
    int            r;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_host_ack", 32'(host_ack), 32'd0);
    chk("rst_host_rdata", 32'(host_rdata), 32'd0);
    chk("rst_mpu_stall", 32'(mpu_stall), 32'd0);
    chk("rst_host_grant", 32'(host_grant), 32'd0);
    reset = 1'b1;

    // Fill the RAM through the CU path.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      d          = DW'($urandom);
      mpu_access = 1'b1;
      mpu_wren   = 1'b1;
      mpu_addr   = AW'(i);
      mpu_wdata  = d;
      ref_mem[i] = d;
    end
    idle(1, 1'b0);

    // CU idle: write then read back address 3.
    do_req(1'b1, 4'd3, 4'hA, 8'h00, 1'b0, 1'b0, 4'd0);
    idle(2, 1'b0);
    do_req(1'b0, 4'd3, 4'h0, 8'h00, 1'b0, 1'b0, 4'd0);

    // CU busy 3 cycles, then idle.
    do_req(1'b0, 4'd9, 4'h0, 8'b0000_0111, 1'b0, 1'b0, 4'd0);

    // CU busy throughout: steal, with a CU write on the stolen cycle.
    do_req(1'b0, 4'd5, 4'h0, 8'hFF, 1'b0, 1'b1, 4'd6);
    do_req(1'b0, 4'd6, 4'h0, 8'h00, 1'b0, 1'b0, 4'd0);

    // Back-to-back requests with req held through ack.
    do_req(1'b1, 4'd7, 4'h5, 8'h00, 1'b1, 1'b0, 4'd0);
    do_req(1'b1, 4'd8, 4'hC, 8'b0000_0011, 1'b1, 1'b0, 4'd0);
    do_req(1'b0, 4'd7, 4'h0, 8'h00, 1'b1, 1'b0, 4'd0);
    do_req(1'b0, 4'd8, 4'h0, 8'h01, 1'b0, 1'b0, 4'd0);

    // Reset during WAIT with a pending host write to address 2.
    @(posedge clk); #1;
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = 4'd2;
    host_wdata = ~ref_mem[2];
    mpu_access = 1'b1;
    mpu_wren   = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      mpu_access = 1'b1;
    end
    reset      = 1'b0;
    mpu_access = 1'b0;
    #1;
    chk("wait_rst_grant", 32'(host_grant), 32'd0);
    chk("wait_rst_wren", 32'(ram_wren), 32'd0);
    chk("wait_rst_rdata", 32'(host_rdata), 32'd0);
    @(posedge clk); #1;
    chk("wait_rst_ack", 32'(host_ack), 32'd0);
    chk("wait_rst_stall", 32'(mpu_stall), 32'd0);
    host_req = 1'b0;
    reset    = 1'b1;
    do_req(1'b0, 4'd2, 4'h0, 8'h00, 1'b0, 1'b0, 4'd0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      r    = int'($urandom_range(0, 3));
      busy = (r == 0) ? 8'hFF : MW'($urandom);
      do_req(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), busy,
             1'b0, 1'b0, 4'd0);
      idle(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

`ifdef DM_ARB_STATS_EN
    // Force enough steals to saturate the steal counter.
    for (int n = 0; n < 300; n++) begin
      do_req(1'b0, AW'($urandom), 4'h0, 8'hFF, 1'b0, 1'b0, 4'd0);
    end
    chk("steal_count_sat", 32'(steal_count), 32'hFF);
    chk("host_wait_max", 32'(host_wait_max), 32'(MW - 1));
`endif

    idle(3, 1'b0);
    chk("pending_acks", 32'(exp_q.size()), 32'd0);
    chk("pending_stalls", 32'(stall_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
